attention_score_mp: RTL and testbench
=====================================

Name: attention_score_mp

Overview:
- Parametrised successor to the single-MAC attention score engine.
- Computes A[l][n][l2] = sat((sum_e Q[l][n][e]*K[l2][n][e]) >>> FRAC_BITS) for all l, l2 in [0,L) and n in [0,N).
- Uses NUM_MAC parallel MAC lanes over the E dimension.
- Adds fixed-point rescale, saturation, and a valid/ready output hold.
- Sits between the QKV projection and softmax stages of the attention datapath.

Parameters:
- DATA_WIDTH, 16, signed element width of Q, K and A.
- L, 8, sequence length; must be at least 2.
- N, 1, batch/head count; all heads are processed in the same cycle.
- E, 8, embedding size; must be divisible by NUM_MAC.
- NUM_MAC, 2, parallel multipliers per head, each covering a slice of E.
- FRAC_BITS, 0, arithmetic right-shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in S_IDLE.
- busy  out  1  high in every state except S_IDLE.
- Q_in  in  DATA_WIDTH*L*N*E  packed Q; flat index (l*N*E+n*E+e).
- K_in  in  DATA_WIDTH*L*N*E  packed K; same layout as Q_in.
- A_out  out  DATA_WIDTH*L*N*L  packed scores; flat index (l*N*L+n*L+l2).
- out_valid  out  1  A_out is valid; held until accepted.
- out_ready  in  1  downstream accept.
- done  out  1  one-cycle pulse on the cycle after the out_valid && out_ready handshake.

Behaviour:
- Reset: state=S_IDLE; busy=0, out_valid=0, done=0, A_out=0; counters and accumulators cleared. Reset asserted mid-operation aborts immediately and discards partial results.
- State S_IDLE: when start=1, go to S_LOAD.
- State S_LOAD: 1 cycle. Register Q_in and K_in, clear all accumulators, zero the counters, then go to S_COMPUTE.
  - Q_in and K_in may change at any time after this cycle.
- State S_COMPUTE: counters l, l2 and ec, where ec counts 0..E/NUM_MAC-1, nested l outermost and ec innermost.
  - Each cycle, for every n: acc += sum over j<NUM_MAC of Q[l][n][ec*NUM_MAC+j]*K[l2][n][ec*NUM_MAC+j].
  - When ec is last, write the result to A[l][n][l2] and clear the accumulator.
  - Leave on the cycle where l=L-1, l2=L-1 and ec is last.
- State S_PACK: 1 cycle. Copy A into A_out, set out_valid=1, then go to S_HOLD.
- State S_HOLD: A_out and out_valid are stable. On out_valid && out_ready: out_valid=0, done=1 for the next cycle, and return to S_IDLE.
- Throughput: out_ready held high gives start-to-out_valid = 2 + L*L*E/NUM_MAC cycles. Defaults: 2 + 8*8*4 = 258 cycles.
- start outside S_IDLE is ignored, with no queuing.
- Back-to-back: start asserted in the cycle done is high is accepted.
- Arithmetic:
  - Products are 2*DATA_WIDTH signed.
  - ACC_W = 2*DATA_WIDTH + clog2(E), so the accumulator never wraps.
  - Scaling is an arithmetic shift right by FRAC_BITS, truncating toward -inf.
  - Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- NUM_MAC = E gives one cycle per score. NUM_MAC = 1 matches the previous engine's cycle count.

Optional Feature:
- Macro: ATTN_SCORE_CAUSAL_MASK_EN.
- Defined: every entry with l2 > l is written as -2^(DATA_WIDTH-1), the most negative value, so softmax yields about 0. Cycle count is unchanged and the MAC still iterates. Entries with l2 <= l are computed normally.
- Undefined: no masking; all L*L entries are computed.

Decomposition:
- Shared package attn_pkg holds:
  - state_t enum: S_IDLE, S_LOAD, S_COMPUTE, S_PACK, S_HOLD.
  - function acc_width(DW, E).
  - function sat_shift(acc, FRAC_BITS, DW), which returns a saturated DW-bit value.
- Sub-module attn_mac_lane holds the per-head logic: NUM_MAC multipliers, adder tree, and ACC_W accumulator with clear and last inputs. It is instantiated N times.

Test Plan:
- Identity: Q=K=identity (1 on e==l), defaults, FRAC_BITS=0 -> A diagonal=1, off-diagonal=0. out_valid at cycle 258 after start.
- Saturation: all Q=K=16'h7FFF -> every entry = 16'h7FFF. All Q=16'h8000, K=16'h7FFF -> every entry = 16'h8000.
- Scaling: FRAC_BITS=8, all Q=K=16'h0100 (value 1.0) -> every entry = 16'h0800 (value 8.0). A dot-product sum of -1 yields -1 after the shift, not 0.
- Backpressure: out_ready low for 20 cycles -> A_out and out_valid stable throughout. done pulses exactly once, one cycle after out_ready rises. start during S_HOLD is ignored.
- Reset mid-compute: rst_n low at cycle 100 -> all outputs are 0 next cycle. A new start produces correct results with no residual accumulator values.
- ATTN_SCORE_CAUSAL_MASK_EN defined with random Q and K -> A[l][n][l2] = 16'h8000 for l2 > l. The lower triangle matches the golden model, and latency is unchanged.

Source files
------------

// File: rtl/attn_pkg.sv
// Shared types and arithmetic helpers for the attention score engine.
// Holds the FSM state enum, accumulator sizing and the rescale/saturate helper.
package attn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_PACK,
    S_HOLD
  } state_t;

  // Working width for the saturating rescale; wide enough for any sane ACC_W.
  localparam int SAT_W = 64;

  function automatic int acc_width(input int dw, input int e);
    return 2 * dw + $clog2(e);
  endfunction

  // Arithmetic shift (floor toward -inf) followed by a clamp to a signed dw-bit range.
  function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] acc,
                                                        input int frac_bits,
                                                        input int dw);
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    shifted = acc >>> frac_bits;
    max_v   = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    if (shifted > max_v)      return max_v;
    else if (shifted < min_v) return min_v;
    else                      return shifted;
  endfunction

endpackage

// File: rtl/attn_mac_lane.sv
// One head's dot-product lane: NUM_MAC signed multipliers, an adder tree and
// an accumulator that clears itself after the last slice of E.
module attn_mac_lane
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_MAC    = 2,
  parameter int E          = 8,
  localparam int ACC_W     = acc_width(DATA_WIDTH, E)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear_i,
  input  logic                             en_i,
  input  logic                             last_i,
  input  logic [NUM_MAC*DATA_WIDTH-1:0]    q_i,
  input  logic [NUM_MAC*DATA_WIDTH-1:0]    k_i,
  output logic signed [ACC_W-1:0]          sum_o
);

  logic signed [2*DATA_WIDTH-1:0] prod [NUM_MAC];
  logic signed [ACC_W-1:0]        partial;
  logic signed [ACC_W-1:0]        acc_q;

  for (genvar j = 0; j < NUM_MAC; j++) begin : g_mul
    logic signed [DATA_WIDTH-1:0] qa;
    logic signed [DATA_WIDTH-1:0] kb;
    assign qa      = q_i[j*DATA_WIDTH +: DATA_WIDTH];
    assign kb      = k_i[j*DATA_WIDTH +: DATA_WIDTH];
    assign prod[j] = (2*DATA_WIDTH)'(qa) * (2*DATA_WIDTH)'(kb);
  end

  always_comb begin
    partial = '0;
    for (int j = 0; j < NUM_MAC; j++) begin
      partial = partial + ACC_W'(prod[j]);
    end
  end

  // sum_o already includes this cycle's slice so the final score is taken combinationally.
  assign sum_o = acc_q + partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= last_i ? '0 : sum_o;
    end
  end

endmodule

// File: rtl/attention_score_mp.sv
// Multi-MAC attention score engine: A[l][n][l2] = sat((Q[l][n].K[l2][n]) >>> FRAC_BITS).
// Define ATTN_SCORE_CAUSAL_MASK_EN to force entries with l2 > l to the most negative value.
module attention_score_mp
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8,
  parameter int NUM_MAC    = 2,
  parameter int FRAC_BITS  = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  input  logic [DATA_WIDTH*L*N*E-1:0]    Q_in,
  input  logic [DATA_WIDTH*L*N*E-1:0]    K_in,
  output logic [DATA_WIDTH*L*N*L-1:0]    A_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           done
);

  localparam int ACC_W = acc_width(DATA_WIDTH, E);
  localparam int EC_N  = E / NUM_MAC;
  localparam int ECW   = (EC_N > 1) ? $clog2(EC_N) : 1;
  localparam int LW    = $clog2(L);
  localparam int SLICE = NUM_MAC * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] A_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [LW-1:0]           l_q, l2_q;
  logic [ECW-1:0]          ec_q;
  logic [SLICE-1:0]        q_q [L][N][EC_N];
  logic [SLICE-1:0]        k_q [L][N][EC_N];
  logic [DATA_WIDTH-1:0]   a_q [L][N][L];
  logic [DATA_WIDTH*L*N*L-1:0] a_out_q;
  logic                    out_valid_q, done_q;
  logic                    ec_last, l2_last, l_last, masked;
  logic signed [ACC_W-1:0] lane_sum [N];

  assign ec_last = (ec_q == ECW'(EC_N - 1));
  assign l2_last = (l2_q == LW'(L - 1));
  assign l_last  = (l_q == LW'(L - 1));

`ifdef ATTN_SCORE_CAUSAL_MASK_EN
  assign masked = (l2_q > l_q);
`else
  assign masked = 1'b0;
`endif

  for (genvar gn = 0; gn < N; gn++) begin : g_lane
    attn_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_MAC   (NUM_MAC),
      .E         (E)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear_i(state_q == S_LOAD),
      .en_i   (state_q == S_COMPUTE),
      .last_i (ec_last),
      .q_i    (q_q[l_q][gn][ec_q]),
      .k_i    (k_q[l2_q][gn][ec_q]),
      .sum_o  (lane_sum[gn])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD;
      S_LOAD:    state_d = S_COMPUTE;
      S_COMPUTE: if (l_last && l2_last && ec_last) state_d = S_PACK;
      S_PACK:    state_d = S_HOLD;
      S_HOLD:    if (out_valid_q && out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q         <= '0;
      l2_q        <= '0;
      ec_q        <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      a_out_q     <= '0;
      for (int l = 0; l < L; l++)
        for (int n = 0; n < N; n++) begin
          for (int c = 0; c < EC_N; c++) begin
            q_q[l][n][c] <= '0;
            k_q[l][n][c] <= '0;
          end
          for (int l2 = 0; l2 < L; l2++) a_q[l][n][l2] <= '0;
        end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          l_q  <= '0;
          l2_q <= '0;
          ec_q <= '0;
          for (int l = 0; l < L; l++)
            for (int n = 0; n < N; n++)
              for (int c = 0; c < EC_N; c++) begin
                q_q[l][n][c] <= Q_in[((l*N + n)*E + c*NUM_MAC)*DATA_WIDTH +: SLICE];
                k_q[l][n][c] <= K_in[((l*N + n)*E + c*NUM_MAC)*DATA_WIDTH +: SLICE];
              end
        end
        S_COMPUTE: begin
          if (ec_last) begin
            ec_q <= '0;
            for (int n = 0; n < N; n++) begin
              a_q[l_q][n][l2_q] <= masked ? A_MIN
                : DATA_WIDTH'(sat_shift(SAT_W'(lane_sum[n]), FRAC_BITS, DATA_WIDTH));
            end
            if (l2_last) begin
              l2_q <= '0;
              l_q  <= l_last ? '0 : l_q + 1'b1;
            end else begin
              l2_q <= l2_q + 1'b1;
            end
          end else begin
            ec_q <= ec_q + 1'b1;
          end
        end
        S_PACK: begin
          for (int l = 0; l < L; l++)
            for (int n = 0; n < N; n++)
              for (int l2 = 0; l2 < L; l2++)
                a_out_q[((l*N + n)*L + l2)*DATA_WIDTH +: DATA_WIDTH] <= a_q[l][n][l2];
          out_valid_q <= 1'b1;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign A_out     = a_out_q;

endmodule

// File: tb/tb_attention_score_mp.sv
// Directed + random bench for attention_score_mp; two instances (FRAC_BITS 0 and 8)
// run in lockstep and are checked against a plain-arithmetic dot-product model.
module tb_attention_score_mp;

  localparam int DW = 16, L = 8, N = 1, E = 8, NUM_MAC = 2;
  localparam int QW = DW*L*N*E, AW = DW*L*N*L;
  localparam int LAT = 2 + L*L*E/NUM_MAC;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [QW-1:0] Q_in = '0, K_in = '0;
  logic busy0, busy8, ov0, ov8, done0, done8;
  logic [AW-1:0] a0, a8;
  logic [AW-1:0] snap0, snap8;
  int vectors = 0, miscompares = 0;
  int qv [L][N][E];
  int kv [L][N][E];
  int cyc;

  always #5 clk = ~clk;

  attention_score_mp #(.DATA_WIDTH(DW), .L(L), .N(N), .E(E), .NUM_MAC(NUM_MAC), .FRAC_BITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .Q_in(Q_in), .K_in(K_in),
    .A_out(a0), .out_valid(ov0), .out_ready(out_ready), .done(done0));

  attention_score_mp #(.DATA_WIDTH(DW), .L(L), .N(N), .E(E), .NUM_MAC(NUM_MAC), .FRAC_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy8), .Q_in(Q_in), .K_in(K_in),
    .A_out(a8), .out_valid(ov8), .out_ready(out_ready), .done(done8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_score(int l, int n, int l2, int frac);
    longint s;
    s = 0;
    for (int e = 0; e < E; e++) s += longint'(qv[l][n][e]) * longint'(kv[l2][n][e]);
    s = s >>> frac;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`ifdef ATTN_SCORE_CAUSAL_MASK_EN
    if (l2 > l) s = -32768;
`endif
    return s[DW-1:0];
  endfunction

  task automatic set_all(input int qval, input int kval);
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++)
        for (int e = 0; e < E; e++) begin
          qv[l][n][e] = qval;
          kv[l][n][e] = kval;
        end
  endtask

  task automatic set_random();
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++)
        for (int e = 0; e < E; e++) begin
          qv[l][n][e] = int'($urandom_range(65535)) - 32768;
          kv[l][n][e] = int'($urandom_range(65535)) - 32768;
        end
  endtask

  task automatic drive_qk();
    int t;
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++)
        for (int e = 0; e < E; e++) begin
          t = qv[l][n][e];
          Q_in[((l*N + n)*E + e)*DW +: DW] = t[DW-1:0];
          t = kv[l][n][e];
          K_in[((l*N + n)*E + e)*DW +: DW] = t[DW-1:0];
        end
  endtask

  task automatic launch(output int c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (!ov0 && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic check_scores(input string name);
    int idx;
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++)
        for (int l2 = 0; l2 < L; l2++) begin
          idx = ((l*N + n)*L + l2)*DW;
          chk($sformatf("%s_f0[%0d][%0d][%0d]", name, l, n, l2), a0[idx +: DW], exp_score(l, n, l2, 0));
          chk($sformatf("%s_f8[%0d][%0d][%0d]", name, l, n, l2), a8[idx +: DW], exp_score(l, n, l2, 8));
        end
  endtask

  // Full transaction with out_ready high; returns in the cycle done is high.
  task automatic run_full(input string name);
    int c;
    drive_qk();
    out_ready = 1'b1;
    launch(c);
    chk({name, "_latency"}, c, LAT);
    chk({name, "_valid8"}, ov8, 1'b1);
    check_scores(name);
    @(posedge clk); #1;
    chk({name, "_done0"}, done0, 1'b1);
    chk({name, "_done8"}, done8, 1'b1);
    chk({name, "_valid_clr"}, ov0, 1'b0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_valid", ov0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_aout0", a0, '0);
    chk("rst_aout8", a8, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++)
        for (int e = 0; e < E; e++) begin
          qv[l][n][e] = (e == l) ? 1 : 0;
          kv[l][n][e] = (e == l) ? 1 : 0;
        end
    run_full("identity");

    set_all(32767, 32767);
    run_full("sat_pos");
    set_all(-32768, 32767);
    run_full("sat_neg");
    set_all(256, 256);
    run_full("scale");

    set_all(0, 0);
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++) begin
        qv[l][n][0] = 1;
        kv[l][n][0] = -1;
      end
    run_full("minus_one");
    chk("floor_shift_neg1", a8[DW-1:0], 16'hFFFF);

    for (int r = 0; r < 3; r++) begin
      set_random();
      run_full($sformatf("rand%0d", r));
    end

    // Backpressure: hold out_ready low while in S_HOLD, poke start meanwhile.
    @(posedge clk); #1;
    set_random();
    drive_qk();
    out_ready = 1'b0;
    launch(cyc);
    chk("bp_latency", cyc, LAT);
    snap0 = a0;
    snap8 = a8;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      @(posedge clk); #1;
      chk($sformatf("bp_stable0_%0d", i), a0 === snap0, 1'b1);
      chk($sformatf("bp_stable8_%0d", i), a8 === snap8, 1'b1);
      chk($sformatf("bp_valid_%0d", i), ov0, 1'b1);
      chk($sformatf("bp_nodone_%0d", i), done0, 1'b0);
    end
    start = 1'b0;
    check_scores("bp");
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done", done0, 1'b1);
    chk("bp_valid_drop", ov0, 1'b0);
    @(posedge clk); #1;
    chk("bp_done_once", done0, 1'b0);
    chk("bp_start_ignored", busy0, 1'b0);

    // Abort mid-compute, then confirm a clean rerun.
    set_random();
    drive_qk();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_busy", busy0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy0, 1'b0);
    chk("abort_valid", ov0, 1'b0);
    chk("abort_done", done0, 1'b0);
    chk("abort_aout0", a0, '0);
    chk("abort_aout8", a8, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_random();
    run_full("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
